// File: rtl/mem_port_master.sv
// mem_port_master: memory-to-stream fetcher and stream-to-memory writer sharing one job launch
module mem_port_master #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W-1:0] wr_base,
  input  logic [ADDR_W-1:0] len,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              busy,
  output logic              done
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] rd_base_q, wr_base_q, len_q, rd_cnt, wr_cnt;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wp, rp;
  logic [CW-1:0]     cnt;
  logic              empty, push, pop, launch;

  always_ff @(posedge clk)
    state <= !rst ? IDLE : state_nx;

  always_comb begin
    state_nx = state;
    if (state == IDLE && start)
      state_nx = (len == '0) ? DONE : RUN;
    else if (state == RUN && rd_cnt == len_q && empty && wr_cnt == len_q)
      state_nx = DONE;
    else if (state == DONE)
      state_nx = IDLE;
  end

  // Request-side strobes are gated by rst so nothing reaches memory during the reset cycle.
  always_comb begin
    launch    = state == IDLE && start;
    empty     = cnt == '0;
    m_valid   = !empty;
    m_data    = empty ? '0 : fifo_mem[rp];
    pop       = m_valid && m_ready;
    push      = rst && state == RUN && rd_cnt < len_q && (cnt != FULL || pop);
    mem_read  = push;
    mem_addr  = push ? rd_base_q + rd_cnt : '0;
    s_ready   = rst && state == RUN && wr_cnt < len_q;
    mem_we    = s_valid && s_ready;
    mem_waddr = wr_base_q + wr_cnt;
    mem_wdata = s_data;
    busy      = state != IDLE;
    done      = state == DONE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_base_q <= '0;
      wr_base_q <= '0;
      len_q     <= '0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      wp        <= '0;
      rp        <= '0;
      cnt       <= '0;
    end else begin
      if (launch) begin
        rd_base_q <= rd_base;
        wr_base_q <= wr_base;
        len_q     <= len;
        rd_cnt    <= '0;
        wr_cnt    <= '0;
      end else begin
        if (push) rd_cnt <= rd_cnt + 1'b1;
        if (mem_we) wr_cnt <= wr_cnt + 1'b1;
      end
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= (push && !pop) ? cnt + 1'b1 : (!push && pop) ? cnt - 1'b1 : cnt;
    end
  end

  // When full, push and pop share a slot: the head is read out before the edge overwrites it.
  always_ff @(posedge clk)
    if (push) fifo_mem[wp] <= mem_rdata;
endmodule

// File: tb/tb_mem_port_master.sv
// tb_mem_port_master: scoreboard bench with a loopback m->s stream and a combinational memory model
module tb_mem_port_master;
  logic        clk = 0, rst = 0, start = 0, m_ready = 0;
  logic [7:0]  rd_base = 0, wr_base = 0, len = 0;
  logic [7:0]  mem_addr, mem_waddr;
  logic        mem_read, mem_we, m_valid, s_ready, busy, done, s_valid;
  logic [31:0] mem_wdata, m_data, s_data;
  wire  [31:0] mem_rdata;
  int          total = 0, bad = 0;
  logic [31:0] exp_rd [$];
  logic [39:0] exp_wr [$];
  logic [31:0] e_rd;
  logic [39:0] e_wr;

  function automatic logic [31:0] init_word(logic [7:0] a);
    return {8'hA5, ~a, a, a ^ 8'h3C};
  endfunction

  assign mem_rdata = mem_read ? init_word(mem_addr) : 32'hzzzz_zzzz;
  assign s_valid   = m_valid && m_ready;
  assign s_data    = m_data;

  always #5 clk = ~clk;

  mem_port_master dut (
    .clk(clk), .rst(rst), .start(start), .rd_base(rd_base), .wr_base(wr_base), .len(len),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_rdata(mem_rdata), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .busy(busy), .done(done)
  );

  always @(negedge clk) begin
    #3;
    if (rst && m_valid && m_ready) begin
      total++;
      if (exp_rd.size() == 0) begin
        bad++;
        $display("FAIL stream_extra got=%h want=none", m_data);
      end else begin
        e_rd = exp_rd.pop_front();
        if (m_data !== e_rd) begin
          bad++;
          $display("FAIL stream_data got=%h want=%h", m_data, e_rd);
        end
      end
    end
    if (mem_we) begin
      total++;
      if (exp_wr.size() == 0) begin
        bad++;
        $display("FAIL write_extra got=%h:%h want=none", mem_waddr, mem_wdata);
      end else begin
        e_wr = exp_wr.pop_front();
        if ({mem_waddr, mem_wdata} !== e_wr) begin
          bad++;
          $display("FAIL write got=%h:%h want=%h:%h", mem_waddr, mem_wdata, e_wr[39:32], e_wr[31:0]);
        end
      end
    end
  end

  task automatic start_job(input logic [7:0] rb, input logic [7:0] wb, input logic [7:0] l);
    @(negedge clk);
    rd_base = rb; wr_base = wb; len = l; start = 1;
    for (int i = 0; i < int'(l); i++) begin
      exp_rd.push_back(init_word(rb + 8'(i)));
      exp_wr.push_back({wb + 8'(i), init_word(rb + 8'(i))});
    end
    @(negedge clk);
    start = 0; rd_base = 8'hEE; wr_base = 8'hDD; len = 8'h77;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk); #1;
      ok = done;
    end
  endtask

  task automatic test_reset;
    rst = 0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL rst_mem_read got=%b want=0", mem_read); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%b want=0", mem_we); end
    total++; if (mem_addr !== 8'h00) begin bad++; $display("FAIL rst_mem_addr got=%h want=00", mem_addr); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid got=%b want=0", m_valid); end
    total++; if (m_data !== 32'h0) begin bad++; $display("FAIL rst_m_data got=%h want=0", m_data); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_s_ready got=%b want=0", s_ready); end
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL rst_busy_done got=%b want=00", {busy, done}); end
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_loopback;
    bit ok;
    m_ready = 1;
    start_job(8'h10, 8'h40, 8'd3);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 1) begin start = 1; len = 8'd0; end
      if (i == 2) start = 0;
      #1;
      total++;
      if (mem_read !== 1'b1 || mem_addr !== 8'(8'h10 + i))
        begin bad++; $display("FAIL loop_fetch%0d got=%b/%h want=1/%h", i, mem_read, mem_addr, 8'(8'h10 + i)); end
    end
    wait_done(ok);
    total++; if (!ok) begin bad++; $display("FAIL loop_done_timeout got=0 want=1"); end
    @(negedge clk); #1;
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL loop_after_done got=%b want=00", {busy, done}); end
    total++; if (exp_rd.size() + exp_wr.size() != 0) begin bad++; $display("FAIL loop_left got=%0d want=0", exp_rd.size() + exp_wr.size()); end
  endtask

  task automatic test_backpressure;
    bit ok;
    m_ready = 0;
    start_job(8'h20, 8'h80, 8'd4);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      total++;
      if (mem_read !== 1'b1 || mem_addr !== 8'(8'h20 + i))
        begin bad++; $display("FAIL bp_fetch%0d got=%b/%h want=1/%h", i, mem_read, mem_addr, 8'(8'h20 + i)); end
    end
    @(negedge clk); #1;
    total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL bp_full_read got=%b want=0", mem_read); end
    total++; if (m_valid !== 1'b1 || m_data !== init_word(8'h20))
      begin bad++; $display("FAIL bp_head got=%b/%h want=1/%h", m_valid, m_data, init_word(8'h20)); end
    @(negedge clk);
    m_ready = 1;
    #1;
    total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL bp_no_refetch got=%b want=0", mem_read); end
    wait_done(ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_done_timeout got=0 want=1"); end
    total++; if (exp_rd.size() + exp_wr.size() != 0) begin bad++; $display("FAIL bp_left got=%0d want=0", exp_rd.size() + exp_wr.size()); end
  endtask

  task automatic test_full_stream;
    bit ok;
    m_ready = 0;
    start_job(8'h50, 8'hB0, 8'd8);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 4) m_ready = 1;
      #1;
      total++;
      if (mem_read !== 1'b1 || mem_addr !== 8'(8'h50 + i))
        begin bad++; $display("FAIL full_fetch%0d got=%b/%h want=1/%h", i, mem_read, mem_addr, 8'(8'h50 + i)); end
    end
    @(negedge clk); #1;
    total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL full_end_read got=%b want=0", mem_read); end
    wait_done(ok);
    total++; if (!ok) begin bad++; $display("FAIL full_done_timeout got=0 want=1"); end
    total++; if (exp_rd.size() + exp_wr.size() != 0) begin bad++; $display("FAIL full_left got=%0d want=0", exp_rd.size() + exp_wr.size()); end
  endtask

  task automatic test_wrap;
    bit ok;
    logic [7:0] want [3];
    want[0] = 8'hFE; want[1] = 8'hFF; want[2] = 8'h00;
    m_ready = 1;
    start_job(8'hFE, 8'h60, 8'd3);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      total++;
      if (mem_read !== 1'b1 || mem_addr !== want[i])
        begin bad++; $display("FAIL wrap_addr%0d got=%b/%h want=1/%h", i, mem_read, mem_addr, want[i]); end
    end
    wait_done(ok);
    total++; if (!ok) begin bad++; $display("FAIL wrap_done_timeout got=0 want=1"); end
    total++; if (exp_rd.size() + exp_wr.size() != 0) begin bad++; $display("FAIL wrap_left got=%0d want=0", exp_rd.size() + exp_wr.size()); end
  endtask

  task automatic test_len_zero;
    start_job(8'h33, 8'h44, 8'd0);
    #1;
    total++; if ({busy, done} !== 2'b11) begin bad++; $display("FAIL zero_done got=%b want=11", {busy, done}); end
    total++; if ({mem_read, mem_we} !== 2'b00) begin bad++; $display("FAIL zero_mem got=%b want=00", {mem_read, mem_we}); end
    @(negedge clk); #1;
    total++; if ({busy, done, mem_read, mem_we} !== 4'b0000) begin bad++; $display("FAIL zero_after got=%b want=0000", {busy, done, mem_read, mem_we}); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    m_ready = 1;
    start_job(8'h30, 8'h90, 8'd5);
    repeat (3) @(negedge clk);
    rst = 0;
    exp_rd.delete();
    exp_wr.delete();
    #1;
    total++; if ({mem_read, mem_we} !== 2'b00) begin bad++; $display("FAIL rmid_gate got=%b want=00", {mem_read, mem_we}); end
    @(negedge clk);
    rst = 1;
    #1;
    total++;
    if ({mem_read, mem_we, m_valid, s_ready, busy, done} !== 6'b0 || mem_addr !== 8'h00 || m_data !== 32'h0)
      begin bad++; $display("FAIL rmid_outputs got=%b/%h/%h want=000000/00/0", {mem_read, mem_we, m_valid, s_ready, busy, done}, mem_addr, m_data); end
    start_job(8'h34, 8'hA0, 8'd2);
    wait_done(ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_done_timeout got=0 want=1"); end
    total++; if (exp_rd.size() + exp_wr.size() != 0) begin bad++; $display("FAIL rmid_left got=%0d want=0", exp_rd.size() + exp_wr.size()); end
  endtask

  initial begin
    test_reset;
    test_loopback;
    test_backpressure;
    test_full_stream;
    test_wrap;
    test_len_zero;
    test_reset_mid;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_master.md
MEM_PORT_MASTER -- requirements
Module: mem_port_master

Interface
REQ-001 SHALL have parameters (name, default, meaning): ADDR_W, 8, memory address width; DATA_W, 32, memory word width; FIFO_DEPTH, 4, read-stream buffer entries (power of two).
REQ-002 SHALL have one clock and a synchronous, active-low reset, with ports as listed below.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous reset, active-low (rst=0 resets on next rising clk).
REQ-005 start  in  1  job-launch pulse; sampled only in IDLE.
REQ-006 rd_base  in  ADDR_W  first source address; latched at start.
REQ-007 wr_base  in  ADDR_W  first destination address; latched at start.
REQ-008 len  in  ADDR_W  job length in words, 0..255; latched at start.
REQ-009 mem_addr  out  ADDR_W  memory read address.
REQ-010 mem_read  out  1  memory read enable; memory drives mem_rdata combinationally while high and is Z otherwise.
REQ-011 mem_rdata  in  DATA_W  memory read data.
REQ-012 mem_we  out  1  memory write enable; the memory commits on the rising clk.
REQ-013 mem_waddr  out  ADDR_W  memory write address.
REQ-014 mem_wdata  out  DATA_W  memory write data.
REQ-015 m_valid / m_ready / m_data  out / in / out  1 / 1 / DATA_W  outbound stream of words read from memory.
REQ-016 s_valid / s_ready / s_data  in / out / in  1 / 1 / DATA_W  inbound stream of words to be written to memory.
REQ-017 busy  out  1  high in RUN and DONE.
REQ-018 done  out  1  one-cycle pulse at job end.

Function
REQ-019 FSM states SHALL be IDLE, RUN, DONE; transition IDLE->RUN on start=1 with len!=0; IDLE->DONE on start=1 with len=0; RUN->DONE when rd_cnt=len, FIFO empty and wr_cnt=len; DONE->IDLE unconditionally after one cycle.
REQ-020 start outside IDLE SHALL be ignored; latched rd_base, wr_base and len SHALL NOT change mid-job.
REQ-021 Fetch: in RUN, while rd_cnt<len and (FIFO count<FIFO_DEPTH or a pop occurs this cycle), mem_read=1 and mem_addr=rd_base+rd_cnt (mod 2^ADDR_W); mem_rdata is pushed into the FIFO at that rising edge and rd_cnt increments.
REQ-022 mem_read SHALL be 0 whenever no fetch occurs; mem_rdata SHALL be ignored (may be Z) then.
REQ-023 FIFO: m_valid=1 when not empty; m_data=head word, 0 when empty; pop on m_valid&&m_ready; push and pop in the same cycle are legal at any fill level, including full.
REQ-024 Fetch-to-m_valid latency SHALL be 1 cycle; word order SHALL equal address order.
REQ-025 Write: s_ready=1 in RUN while wr_cnt<len, else 0; on s_valid&&s_ready, in the same cycle: mem_we=1, mem_waddr=wr_base+wr_cnt (mod 2^ADDR_W), mem_wdata=s_data; wr_cnt increments at that edge.
REQ-026 mem_we SHALL be 0 when no handshake occurs; mem_waddr/mem_wdata are don't-care then.
REQ-027 Read and write channels SHALL proceed independently and concurrently; overlapping source/destination ranges are not hazard-checked.
REQ-028 Address wrap past 2^ADDR_W-1 SHALL roll to 0 with no error; the caller keeps addresses inside the populated memory range.
REQ-029 rd_cnt and wr_cnt SHALL be ADDR_W bits wide and compare against len exactly.
REQ-030 done SHALL be 1 exactly in the DONE cycle.

Reset
REQ-031 On rst=0 at a rising edge, including mid-job: state=IDLE, counters=0, FIFO emptied.
REQ-032 Reset values: mem_read=0, mem_we=0, mem_addr=0, m_valid=0, m_data=0, s_ready=0, busy=0, done=0.
REQ-033 A write in progress in the reset cycle SHALL NOT be issued (mem_we=0 while rst=0).

Verification
REQ-034 rd_base=0x10, wr_base=0x40, len=3, m_ready=1, loopback m->s -> reads 0x10..0x12 on three consecutive cycles; writes of the same words to 0x40..0x42; done pulses once; busy falls next cycle.
REQ-035 len=4, m_ready=0 -> four fetches fill the FIFO, then mem_read=0; first m_ready=1 cycle pops the word from rd_base and fetches no further (rd_cnt=len).
REQ-036 len=0 start -> DONE the next cycle, done=1 for one cycle, no mem_read/mem_we activity.
REQ-037 rd_base=0xFE, len=3 -> mem_addr sequence 0xFE, 0xFF, 0x00.
REQ-038 rst=0 after 2 of 5 words -> next cycle all outputs at reset values; a new start with len=2 completes normally.
REQ-039 FIFO full, m_ready=1 with rd_cnt<len -> simultaneous pop and fetch, count stays FIFO_DEPTH, data order preserved.
